vit_trellis_ctrl: RTL

//  Sequencer for the 64-state hard-decision BMC/ACS array. Accepts rx symbol pairs over valid/ready,

---
 rtl/vit_pkg.sv | 14 +
 rtl/vit_sm_addr_gen.sv | 41 ++++
 rtl/vit_trellis_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vit_pkg.sv
// Shared constants and types for the 64-state hard-decision Viterbi datapath control.
package vit_pkg;

  localparam int K          = 7;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam int PAIR_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/vit_sm_addr_gen.sv
// Survivor-memory write pointer (wraps mod SM_DEPTH) and traceback window counter.
module vit_sm_addr_gen #(
  parameter int TB_DEPTH = 32,
  parameter int SM_DEPTH = 128,
  parameter int AW       = $clog2(SM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          step,
  input  logic          last,
  output logic [AW-1:0] wr_ptr,
  output logic [AW:0]   since_inc,
  output logic          window_full
);

  localparam logic [AW:0] WIN_LEN  = (AW + 1)'(2 * TB_DEPTH);
  localparam logic [AW:0] KEEP_LEN = (AW + 1)'(TB_DEPTH);

  logic [AW:0] since_tb;

  assign since_inc   = since_tb + 1'b1;
  assign window_full = (since_inc == WIN_LEN);

  // After a mid-frame window the newest TB_DEPTH columns are retained as
  // the overlap for the next window, so the count restarts at TB_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      since_tb <= '0;
    end else begin
      if (step) wr_ptr <= wr_ptr + 1'b1;
      if (clear) begin
        since_tb <= '0;
      end else if (step) begin
        since_tb <= (window_full && !last) ? KEEP_LEN : since_inc;
      end
    end
  end

endmodule

// File: rtl/vit_trellis_ctrl.sv
// Sequencer for the BMC/ACS array: pair intake, ACS stepping, survivor addressing, traceback windows.
// Optional build macro VIT_PM_NORM_EN enables path-metric normalization requests via pm_hi/acs_norm.
module vit_trellis_ctrl
  import vit_pkg::*;
#(
  parameter int  TB_DEPTH  = 32,
  parameter int  FRAME_LEN = 256,
  parameter int  SM_DEPTH  = 128,
  localparam int AW        = $clog2(SM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              rx_valid,
  input  logic [PAIR_W-1:0] rx_pair,
  output logic              rx_ready,
  output logic [PAIR_W-1:0] bmc_rx_pair,
  output logic              acs_en,
  output logic              acs_init,
  output logic              acs_norm,
  input  logic              pm_hi,
  output logic              sm_wr_en,
  output logic [AW-1:0]     sm_wr_addr,
  output logic              tb_req,
  input  logic              tb_ack,
  output logic [AW-1:0]     tb_start_addr,
  output logic [AW:0]       tb_len,
  output logic              tb_last,
  output logic              busy,
  output logic              frame_done,
  output ctrl_state_e       dbg_state
);

  localparam int            CW         = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FRAME_CNT  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX   = CW'(FRAME_LEN - 1);
  localparam logic [AW:0]   TB_LEN_MID = (AW + 1)'(TB_DEPTH);

  // Handshakes: a pair transfers on a rising edge where rx_valid && rx_ready;
  // rx_ready is a flop with no path from rx_valid. A traceback transfers on a
  // rising edge where tb_req && tb_ack; tb_req and the tb_* fields hold until then.

  ctrl_state_e   state, state_next;
  logic [CW-1:0] sym_cnt, sym_cnt_next;
  logic          accept, is_last, enter_run;
  logic          tb_fire, tb_fire_next;
  logic          tb_req_next, done_next, rx_ready_next;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   since_inc;
  logic          window_full;

  assign accept    = rx_valid && rx_ready;
  assign is_last   = (sym_cnt == LAST_IDX);
  assign sm_wr_en  = acs_en;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  vit_sm_addr_gen #(
    .TB_DEPTH (TB_DEPTH),
    .SM_DEPTH (SM_DEPTH),
    .AW       (AW)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (enter_run),
    .step        (accept),
    .last        (is_last),
    .wr_ptr      (wr_ptr),
    .since_inc   (since_inc),
    .window_full (window_full)
  );

  always_comb begin
    state_next    = state;
    sym_cnt_next  = sym_cnt;
    enter_run     = 1'b0;
    tb_fire_next  = 1'b0;
    tb_req_next   = tb_req;
    done_next     = 1'b0;
    rx_ready_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_next   = RUN;
          enter_run    = 1'b1;
          sym_cnt_next = '0;
        end
      end
      RUN: begin
        if (accept) begin
          sym_cnt_next = sym_cnt + CW'(1);
          tb_fire_next = window_full || is_last;
        end
        if (tb_fire && tb_last) state_next = FINAL;
      end
      FINAL: begin
        if (tb_req && tb_ack) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (tb_fire) begin
      tb_req_next = 1'b1;
    end else if (tb_req && tb_ack) begin
      tb_req_next = 1'b0;
    end
    // Intake stops the moment a window is scheduled, so no step lands under a pending request.
    rx_ready_next = (state_next == RUN) && !tb_req_next && !tb_fire_next &&
                    (sym_cnt_next < FRAME_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sym_cnt       <= '0;
      rx_ready      <= 1'b0;
      bmc_rx_pair   <= '0;
      acs_en        <= 1'b0;
      acs_init      <= 1'b0;
      sm_wr_addr    <= '0;
      tb_fire       <= 1'b0;
      tb_req        <= 1'b0;
      tb_start_addr <= '0;
      tb_len        <= '0;
      tb_last       <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state      <= state_next;
      sym_cnt    <= sym_cnt_next;
      rx_ready   <= rx_ready_next;
      tb_fire    <= tb_fire_next;
      tb_req     <= tb_req_next;
      frame_done <= done_next;
      acs_en     <= accept;
      acs_init   <= accept && (sym_cnt == '0);
      if (accept) begin
        bmc_rx_pair <= rx_pair;
        sm_wr_addr  <= wr_ptr;
      end
      // Final window wins over a mid-frame window landing on the same step.
      if (tb_fire_next) begin
        tb_start_addr <= wr_ptr;
        tb_last       <= is_last;
        tb_len        <= is_last ? since_inc : TB_LEN_MID;
      end
    end
  end

`ifdef VIT_PM_NORM_EN
  logic norm_pend;

  // pm_hi seen on a step arms normalization for the following step; the init step never normalizes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      norm_pend <= 1'b0;
      acs_norm  <= 1'b0;
    end else begin
      acs_norm <= accept && (sym_cnt != '0) && (norm_pend || (acs_en && pm_hi));
      if (enter_run || accept) begin
        norm_pend <= 1'b0;
      end else if (acs_en && pm_hi) begin
        norm_pend <= 1'b1;
      end
    end
  end
`else
  logic pm_hi_unused;

  assign pm_hi_unused = pm_hi;
  assign acs_norm     = 1'b0;
`endif

endmodule
